imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 12 +
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 102 ++++++++++
 tb/tb_imem_loader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory constants and loader state codes.
// Imported by the loader, its byte packer and the instruction memory.
package imem_loader_pkg;
  localparam int IMEM_DEPTH  = 32;
  localparam int IMEM_ADDR_W = 5;
  localparam int INSTR_W     = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four little-endian bytes into one instruction word.
// The word register is loaded as byte 3 arrives and holds until the next word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [7:0]         din,
  output logic               full,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);
  logic [1:0]  byte_cnt;
  logic [23:0] sr;

  // Only three bytes are buffered; the fourth goes straight into the word.
  assign full = push & (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      byte_cnt   <= 2'd0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= full;
      if (push) begin
        byte_cnt <= byte_cnt + 2'd1;
        sr       <= {din, sr[23:8]};
        if (full) word <= {din, sr};
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port.
// Holds the core for the whole load and writes words to consecutive addresses.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [ADDR_W:0] len,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              len_ok, take_start, kill, push, full, word_valid;
  logic [INSTR_W-1:0] word;

  assign len_ok     = (len != '0) && (len <= DEPTH_L);
  assign take_start = (state == IDLE) & start & len_ok;
  assign kill       = abort & (state != IDLE);
  assign push       = in_valid & in_ready & ~abort;

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (kill | take_start),
    .push       (push),
    .din        (in_data),
    .full       (full),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q    <= len;
              word_cnt <= '0;
              err_q    <= 1'b0;
              state    <= RECV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (abort) state <= IDLE;
          else if (full) begin
            addr_q <= word_cnt;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (abort) state <= IDLE;
          else if ({1'b0, word_cnt} == len_q - (ADDR_W+1)'(1)) state <= DONE;
          else begin
            word_cnt <= word_cnt + ADDR_W'(1);
            state    <= RECV;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The write strobe is a flop; abort landing on the WRITE cycle still cancels it.
  assign mem_we    = word_valid & ~abort;
  assign mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q};
  assign mem_wdata = word;
  assign in_ready  = (state == RECV);
  assign busy      = (state == RECV) | (state == WRITE);
  assign cpu_hold  = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start vectors, directed loads, aborts and random programs.
module tb_imem_loader;
  logic        clk = 0, rst_n = 0;
  logic        start = 0, abort = 0, in_valid = 0;
  logic [5:0]  len = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, viol = 0;
  logic [63:0] wq[$];
  logic [31:0] prog[32];

  // Observer: record writes and protocol relations away from the clock edge.
  always @(negedge clk) if (rst_n) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
    if (busy && (in_ready == mem_we)) viol++;
    if (done && !cpu_hold) viol++;
    if (busy && !cpu_hold) viol++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [5:0] l);
    start = 1; len = l; tick(); start = 0;
  endtask

  task automatic pulse_abort();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    logic ok;
    int   t;
    repeat ($urandom_range(0, maxgap)) tick();
    in_valid = 1; in_data = b; t = 0;
    do begin
      @(negedge clk); ok = in_ready; tick(); t++;
    end while (!ok && t < 50);
    in_valid = 0; in_data = $urandom;
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  // Reference: a load of n words must yield exactly writes (i, prog[i]) for i in 0..n-1.
  task automatic run_load(input int n, input int maxgap, input int ign_at);
    wq.delete(); done_cnt = 0; viol = 0;
    pulse_start(6'(n));
    for (int i = 0; i < n; i++) begin
      if (i == ign_at) pulse_start(6'd1);
      for (int k = 0; k < 4; k++) send_byte(prog[i][8*k +: 8], maxgap);
    end
    for (int t = 0; t < 10 && done_cnt == 0; t++) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("write_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk("write_addr", wq[i][63:32], i);
      chk("write_data", wq[i][31:0], prog[i]);
    end
    @(negedge clk);
    chk("hold_after_done", cpu_hold, 0);
    chk("busy_after_done", busy, 0);
    chk("protocol_viol", viol, 0);
    tick();
  endtask

  typedef struct { logic [5:0] len; logic exp_err; logic exp_busy; } lv_t;
  lv_t tv[6];

  initial begin
    tv[0] = '{6'd0,  1'b1, 1'b0};
    tv[1] = '{6'd33, 1'b1, 1'b0};
    tv[2] = '{6'd63, 1'b1, 1'b0};
    tv[3] = '{6'd32, 1'b0, 1'b1};
    tv[4] = '{6'd1,  1'b0, 1'b1};
    tv[5] = '{6'd0,  1'b1, 1'b0};

    #12;
    chk("rst_outputs", {in_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata}, 0);
    rst_n = 1; tick();

    // Single word
    prog[0] = 32'h00110202;
    run_load(1, 0, -1);

    // Three words with gaps
    prog[0] = 32'h00110202; prog[1] = 32'h00110203; prog[2] = 32'h06a58041;
    run_load(3, 3, -1);

    // Start validation vectors
    for (int i = 0; i < 6; i++) begin
      wq.delete();
      pulse_start(tv[i].len);
      @(negedge clk);
      chk("tv_err", err, tv[i].exp_err);
      chk("tv_busy", busy, tv[i].exp_busy);
      chk("tv_hold", cpu_hold, tv[i].exp_busy);
      tick();
      if (tv[i].exp_busy) pulse_abort();
      chk("tv_no_write", wq.size(), 0);
    end

    // Asynchronous reset mid-RECV
    pulse_start(6'd2);
    send_byte(8'hA5, 0); send_byte(8'h5A, 0);
    #3 rst_n = 0; #1;
    chk("async_rst_outputs", {in_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata}, 0);
    tick(); rst_n = 1; tick();
    chk("post_rst_idle", {busy, cpu_hold, in_ready}, 0);

    // Abort partway through word 1
    for (int i = 0; i < 4; i++) prog[i] = $urandom;
    wq.delete(); done_cnt = 0;
    pulse_start(6'd4);
    for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 1);
    send_byte(prog[1][7:0], 1); send_byte(prog[1][15:8], 1);
    tick(); pulse_abort();
    repeat (3) tick();
    chk("abort_write_count", wq.size(), 1);
    if (wq.size() > 0) chk("abort_word0", wq[0], {32'd0, prog[0]});
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", {busy, cpu_hold}, 0);
    chk("abort_err_kept", err, 0);

    // Full depth with an ignored start midway
    for (int i = 0; i < 32; i++) prog[i] = $urandom;
    run_load(32, 1, 10);
    chk("last_addr", mem_addr, 31);

    // Random programs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      run_load(n, $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
